if_fetch_stage: RTL

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, redirect priority, instruction-memory
// handshake FSM (FETCH/WAIT/HOLD/DROP) and the IF/ID pipeline register.
//
// Handshake: imem_req/imem_addr form a request; the memory completes it in the
// cycle it raises imem_ready with imem_rdata valid. While imem_req is high in
// WAIT or DROP the address is held stable until imem_ready is seen.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        EX_Branch_EN,
    input  logic [31:0] EX_ConBA,
    input  logic        ID_Jump_EN,
    input  logic [31:0] ID_JumpTarget,
    input  logic        IRQ,
    input  logic        Exception,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_PC,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_Instr,
    output logic        ID_Valid,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] hold_buf;
    logic [31:0] id_pc_q;
    logic [31:0] id_instr_q;
    logic        id_valid_q;

    logic        irq_take;
    logic        redirect;
    logic [31:0] next_pc;

    // Interrupts are masked while the PC is in the upper (kernel) half.
    always_comb begin
        irq_take = IRQ & ~pc[31];
        redirect = Exception | irq_take | EX_Branch_EN | ID_Jump_EN;
        if (Exception)
            next_pc = XADR_PC;
        else if (irq_take)
            next_pc = ILLOP_PC;
        else if (EX_Branch_EN)
            next_pc = EX_ConBA;
        else if (ID_Jump_EN)
            next_pc = ID_JumpTarget;
        else
            next_pc = pc + 32'd4;
    end

    always_comb begin
        imem_req = 1'b0;
        case (state)
            FETCH:   imem_req = ~Stall;
            WAIT:    imem_req = 1'b1;
            HOLD:    imem_req = 1'b0;
            DROP:    imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
        if (reset)
            imem_req = 1'b0;
    end

    // DROP keeps presenting the abandoned address so the memory can finish it.
    assign imem_addr = (state == DROP) ? drop_addr : pc;
    assign IF_PC     = pc;
    assign ID_PC     = id_pc_q;
    assign ID_Instr  = id_instr_q;
    assign ID_Valid  = id_valid_q;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drop_addr  <= 32'h0;
            hold_buf   <= 32'h0;
            id_pc_q    <= 32'h0;
            id_instr_q <= 32'h0;
            id_valid_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc         <= next_pc;
                        id_pc_q    <= 32'h0;
                        id_instr_q <= 32'h0;
                        id_valid_q <= 1'b0;
                    end else if (!Stall) begin
                        if (imem_ready) begin
                            id_pc_q    <= pc;
                            id_instr_q <= imem_rdata;
                            id_valid_q <= 1'b1;
                            pc         <= next_pc;
                        end else begin
                            id_pc_q    <= 32'h0;
                            id_instr_q <= 32'h0;
                            id_valid_q <= 1'b0;
                            state      <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (redirect) begin
                        // Late data for the wrong path is either dropped now or
                        // waited out in DROP.
                        pc         <= next_pc;
                        id_pc_q    <= 32'h0;
                        id_instr_q <= 32'h0;
                        id_valid_q <= 1'b0;
                        if (imem_ready) begin
                            state <= FETCH;
                        end else begin
                            drop_addr <= pc;
                            state     <= DROP;
                        end
                    end else if (imem_ready) begin
                        if (Stall) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            id_pc_q    <= pc;
                            id_instr_q <= imem_rdata;
                            id_valid_q <= 1'b1;
                            pc         <= next_pc;
                            state      <= FETCH;
                        end
                    end else if (!Stall) begin
                        id_pc_q    <= 32'h0;
                        id_instr_q <= 32'h0;
                        id_valid_q <= 1'b0;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc         <= next_pc;
                        hold_buf   <= 32'h0;
                        id_pc_q    <= 32'h0;
                        id_instr_q <= 32'h0;
                        id_valid_q <= 1'b0;
                        state      <= FETCH;
                    end else if (!Stall) begin
                        id_pc_q    <= pc;
                        id_instr_q <= hold_buf;
                        id_valid_q <= 1'b1;
                        pc         <= next_pc;
                        hold_buf   <= 32'h0;
                        state      <= FETCH;
                    end
                end

                DROP: begin
                    if (redirect)
                        pc <= next_pc;
                    if (imem_ready)
                        state <= FETCH;
                    if (!Stall) begin
                        id_pc_q    <= 32'h0;
                        id_instr_q <= 32'h0;
                        id_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule
